bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded digits (1..8).
REQ-002 SHALL have parameter MOD, default 10, per-digit modulus (2..16).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 MR  input  1  master reset, synchronous, active-high.
REQ-006 Load  input  1  parallel load of P.
REQ-007 Enable  input  1  count enable.
REQ-008 Up  input  1  direction: 1 = up, 0 = down.
REQ-009 P  input  4*DIGITS  parallel load value, digit 0 in bits [3:0].
REQ-010 Q  output  4*DIGITS  registered count, digit 0 in bits [3:0].
REQ-011 TC  output  1  terminal count, combinational, for cascading.
REQ-012 Wrapped  output  1  registered one-cycle pulse when the count wraps.

Function
REQ-013 Priority per edge SHALL be MR > Load > Enable > hold.
REQ-014 Load SHALL write P into Q, one digit at a time; any digit of P >= MOD SHALL load as 0.
REQ-015 Up count: digit 0 SHALL increment each enabled edge; digit k SHALL step only when digits 0..k-1 are all MOD-1.
REQ-016 Down count: digit 0 SHALL decrement each enabled edge; digit k SHALL step only when digits 0..k-1 are all 0.
REQ-017 A digit stepping up from MOD-1 SHALL become 0; a digit stepping down from 0 SHALL become MOD-1.
REQ-018 TC SHALL = Enable & ~Load & (Up ? all digits == MOD-1 : all digits == 0).
REQ-019 Wrapped SHALL be 1 in the cycle after an edge where TC was 1 and the count wrapped, and 0 otherwise.
REQ-020 Up or P SHALL take effect on the same edge they are sampled; there SHALL be no pipeline latency.
REQ-021 Digit arithmetic SHALL use 5-bit intermediates, so MOD=16 wraps without overflow artefacts.
REQ-022 With Enable=0 and Load=0, Q SHALL hold.

Reset
REQ-023 On MR=1 at a rising CLK edge, Q SHALL be 0 and Wrapped SHALL be 0, regardless of Load and Enable.
REQ-024 MR SHALL have no effect between clock edges.
REQ-025 TC SHALL be 0 whenever all digits are not at terminal value, including directly after reset with Up=1.
REQ-026 MR asserted mid-count SHALL abandon the count; there SHALL be no partial-digit update on that edge.

Configuration
REQ-027 Macro BCD_CNT_SATURATE_EN SHALL select saturating mode.
REQ-028 With BCD_CNT_SATURATE_EN defined, an enabled step at the terminal value SHALL hold Q (all MOD-1 going up, all 0 going down), and Wrapped SHALL stay 0.
REQ-029 With BCD_CNT_SATURATE_EN defined, TC SHALL behave unchanged.
REQ-030 With BCD_CNT_SATURATE_EN undefined, the count SHALL wrap per REQ-017.

Structure
REQ-031 Package bcd_counter_pkg SHALL hold:
- DIGIT_W = 4
- typedef digit_t (logic [3:0])
- typedef enum dir_t {DOWN, UP}
REQ-032 Sub-module bcd_digit SHALL implement one digit, with:
- inputs: step, up, load, load value, MR
- outputs: digit, at_max, at_min
REQ-033 The top level SHALL instantiate DIGITS bcd_digit cells via generate and chain the step enables.

Verification (DIGITS=2, MOD=10)
REQ-034 Load P=8'h98, Up=1, Enable=1 for 2 edges -> Q=99 with TC=1, then Q=00 and Wrapped=1 for one cycle.
REQ-035 MR=0, Q=00, Up=0, Enable=1, one edge -> TC=1 before the edge, Q=99 after, Wrapped=1.
REQ-036 Load P=8'h3A -> Q=8'h30.
REQ-037 MR=1 with Load=1, P=8'h55 and Enable=1 in the same cycle -> Q=00, Wrapped=0.
REQ-038 Q=8'h19, Up=1, one edge -> Q=8'h20; then Up=0, one edge -> Q=8'h19 (carry and borrow across digits).
REQ-039 With BCD_CNT_SATURATE_EN defined: Q=99, Up=1, 3 enabled edges -> Q stays 99, TC=1 each cycle, Wrapped=0.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types for the cascaded BCD up/down counter.
package bcd_counter_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/bcd_digit.sv
// One counter digit of modulus Mod: synchronous reset, clamped parallel load, up/down step.
module bcd_digit
    import bcd_counter_pkg::*;
#(
    parameter int unsigned Mod = 10
) (
    input  logic   clk_i,
    input  logic   mr_i,
    input  logic   step_i,
    input  dir_t   up_i,
    input  logic   load_i,
    input  digit_t load_val_i,
    output digit_t digit_o,
    output logic   at_max_o,
    output logic   at_min_o
);

    // 5-bit arithmetic keeps Mod=16 free of 4-bit overflow.
    localparam logic [4:0] ModW = 5'(Mod);
    localparam logic [4:0] MaxW = 5'(Mod - 1);

    digit_t     digit_q, digit_d;
    logic [4:0] ext;

    assign ext = {1'b0, digit_q};

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = ({1'b0, load_val_i} >= ModW) ? '0 : load_val_i;
        end else if (step_i) begin
            if (up_i == UP) begin
                digit_d = (ext == MaxW) ? '0 : digit_t'(ext + 5'd1);
            end else begin
                digit_d = (ext == 5'd0) ? digit_t'(MaxW) : digit_t'(ext - 5'd1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mr_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign at_max_o = (ext == MaxW);
    assign at_min_o = (digit_q == '0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with terminal count and wrap pulse.
// Define BCD_CNT_SATURATE_EN to hold at the terminal value instead of wrapping.
module bcd_updown_counter
    import bcd_counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned MOD    = 10
) (
    input  logic                  CLK,
    input  logic                  MR,
    input  logic                  Load,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic [4*DIGITS-1:0]   P,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  Wrapped
);

    dir_t              dir;
    logic [DIGITS-1:0] at_max, at_min, carry;
    logic [DIGITS:0]   step;
    logic              cnt_en, at_term;
    logic              wrapped_q, wrapped_d;

    assign dir     = Up ? UP : DOWN;
    assign cnt_en  = Enable & ~Load;
    assign at_term = (dir == UP) ? (&at_max) : (&at_min);
    assign TC      = cnt_en & at_term;

`ifdef BCD_CNT_SATURATE_EN
    assign step[0]   = cnt_en & ~at_term;
    assign wrapped_d = 1'b0;
`else
    assign step[0]   = cnt_en;
    assign wrapped_d = TC;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        // Digit k+1 steps only when this digit rolls over in the current direction.
        assign carry[k]    = (dir == UP) ? at_max[k] : at_min[k];
        assign step[k + 1] = step[k] & carry[k];

        bcd_digit #(
            .Mod (MOD)
        ) u_digit (
            .clk_i      (CLK),
            .mr_i       (MR),
            .step_i     (step[k]),
            .up_i       (dir),
            .load_i     (Load),
            .load_val_i (P[4*k +: 4]),
            .digit_o    (Q[4*k +: 4]),
            .at_max_o   (at_max[k]),
            .at_min_o   (at_min[k])
        );
    end

    always_ff @(posedge CLK) begin
        if (MR) begin
            wrapped_q <= 1'b0;
        end else begin
            wrapped_q <= wrapped_d;
        end
    end

    assign Wrapped = wrapped_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter with DIGITS=2, MOD=10.
module tb_bcd_updown_counter;

    logic       CLK = 1'b0;
    logic       MR = 1'b0;
    logic       Load = 1'b0;
    logic       Enable = 1'b0;
    logic       Up = 1'b1;
    logic [7:0] P = 8'h00;
    logic [7:0] Q;
    logic       TC;
    logic       Wrapped;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BCD_CNT_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    bcd_updown_counter #(
        .DIGITS (2),
        .MOD    (10)
    ) dut (
        .CLK     (CLK),
        .MR      (MR),
        .Load    (Load),
        .Enable  (Enable),
        .Up      (Up),
        .P       (P),
        .Q       (Q),
        .TC      (TC),
        .Wrapped (Wrapped)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mr, input logic ld, input logic en, input logic up,
                         input logic [7:0] p);
        MR = mr; Load = ld; Enable = en; Up = up; P = p;
        #1;
    endtask

    initial begin
        // Reset
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        check_eq("reset_q", 32'(Q), 32'h00);
        check_eq("reset_wrapped", 32'(Wrapped), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("reset_tc_up", 32'(TC), 32'h0);

        // Load then MR with Load/Enable active
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
        tick();
        check_eq("load_42", 32'(Q), 32'h42);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        tick();
        check_eq("mr_over_load_q", 32'(Q), 32'h00);
        check_eq("mr_over_load_wr", 32'(Wrapped), 32'h0);

        // Out-of-range digits clamp to 0
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h3A);
        tick();
        check_eq("load_3a", 32'(Q), 32'h30);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hC5);
        tick();
        check_eq("load_c5", 32'(Q), 32'h05);

        // Up wrap from 98
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        tick();
        check_eq("load_98", 32'(Q), 32'h98);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check_eq("tc_at_98", 32'(TC), 32'h0);
        tick();
        check_eq("up_99", 32'(Q), 32'h99);
        check_eq("tc_at_99", 32'(TC), 32'h1);
        check_eq("wr_at_99", 32'(Wrapped), 32'h0);
        tick();
        check_eq("up_wrap_q", 32'(Q), Sat ? 32'h99 : 32'h00);
        check_eq("up_wrap_wr", 32'(Wrapped), Sat ? 32'h0 : 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_eq("tc_no_enable", 32'(TC), 32'h0);
        tick();
        check_eq("wr_one_cycle", 32'(Wrapped), 32'h0);

        // Down wrap from 00
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("tc_down_00", 32'(TC), 32'h1);
        tick();
        check_eq("down_wrap_q", 32'(Q), Sat ? 32'h00 : 32'h99);
        check_eq("down_wrap_wr", 32'(Wrapped), Sat ? 32'h0 : 32'h1);

        // Carry and borrow across digits
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h19);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        check_eq("carry_20", 32'(Q), 32'h20);
        check_eq("carry_wr", 32'(Wrapped), 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        check_eq("borrow_19", 32'(Q), 32'h19);

        // Hold
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        tick();
        tick();
        check_eq("hold_19", 32'(Q), 32'h19);

        // Load beats Enable; TC masked while loading
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        check_eq("tc_masked_load", 32'(TC), 32'h0);
        tick();
        check_eq("load_over_en", 32'(Q), 32'h99);

        // MR mid-count abandons the step
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h57);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        check_eq("count_58", 32'(Q), 32'h58);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        check_eq("mr_mid_count", 32'(Q), 32'h00);

`ifdef BCD_CNT_SATURATE_EN
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check_eq("sat_tc", 32'(TC), 32'h1);
            tick();
            check_eq("sat_q", 32'(Q), 32'h99);
            check_eq("sat_wr", 32'(Wrapped), 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
